// File: rtl/benc_322_pkg.sv
// Shared constants for the rate-2/3 (3,2,2) convolutional encoder: generator masks, tail length, FSM states.
package benc_322_pkg;

    localparam int K_BITS   = 2;
    localparam int N_BITS   = 3;
    localparam int M_BITS   = 3;
    localparam int TAIL_LEN = 2;

    // Generator masks over {u1,u0,s1a,s1b,s0a}
    localparam logic [4:0] G_V2 = 5'b11010;
    localparam logic [4:0] G_V1 = 5'b10101;
    localparam logic [4:0] G_V0 = 5'b01111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TAIL1 = 2'd2,
        TAIL2 = 2'd3
    } fsm_t;

endpackage

// File: rtl/benc_322_fn.sv
// Combinational trellis step: {u, state} -> {code, next_state}, state = {s1a,s1b,s0a}.
module benc_fn_322
    import benc_322_pkg::*;
(
    input  logic [K_BITS-1:0] u,
    input  logic [M_BITS-1:0] state,
    output logic [N_BITS-1:0] code,
    output logic [M_BITS-1:0] next_state
);

    logic [4:0] taps;

    assign taps       = {u, state};
    assign code       = {^(taps & G_V2), ^(taps & G_V1), ^(taps & G_V0)};
    assign next_state = {u[1], state[2], u[0]};

endmodule

// File: rtl/benc_322.sv
// Rate-2/3 convolutional encoder with valid/ready streams and a one-stage output register.
// Define BENC322_TAIL_EN for zero-tail termination; otherwise frames are truncated on in_last.
module benc_322
    import benc_322_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_code,
    output logic             out_last,
    output logic [CNT_W-1:0] sym_count
);

    fsm_t       fsm_reg;
    logic [2:0] enc_state_reg;
    logic       slot_free;
    logic       in_tail;
    logic [1:0] enc_u;
    logic [2:0] enc_code;
    logic [2:0] enc_next;

    assign slot_free = !out_valid || out_ready;
    assign in_tail   = (fsm_reg == TAIL1) || (fsm_reg == TAIL2);
    assign in_ready  = !in_tail && slot_free;
    assign enc_u     = in_tail ? 2'b00 : in_data;

    benc_fn_322 u_fn (
        .u          (enc_u),
        .state      (enc_state_reg),
        .code       (enc_code),
        .next_state (enc_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_reg       <= IDLE;
            enc_state_reg <= '0;
            out_valid     <= 1'b0;
            out_code      <= '0;
            out_last      <= 1'b0;
            sym_count     <= '0;
        end else if (slot_free) begin
            // Output register drains by default; a new symbol below overrides this.
            out_valid <= 1'b0;
            unique case (fsm_reg)
                IDLE, DATA: begin
                    if (in_valid) begin
                        out_valid <= 1'b1;
                        out_code  <= enc_code;
                        sym_count <= (fsm_reg == IDLE) ? CNT_W'(1) : sym_count + CNT_W'(1);
`ifdef BENC322_TAIL_EN
                        out_last      <= 1'b0;
                        enc_state_reg <= enc_next;
                        fsm_reg       <= in_last ? TAIL1 : DATA;
`else
                        out_last      <= in_last;
                        enc_state_reg <= in_last ? 3'b000 : enc_next;
                        fsm_reg       <= in_last ? IDLE : DATA;
`endif
                    end
                end
`ifdef BENC322_TAIL_EN
                TAIL1: begin
                    out_valid     <= 1'b1;
                    out_code      <= enc_code;
                    out_last      <= 1'b0;
                    sym_count     <= sym_count + CNT_W'(1);
                    enc_state_reg <= enc_next;
                    fsm_reg       <= TAIL2;
                end
                TAIL2: begin
                    out_valid     <= 1'b1;
                    out_code      <= enc_code;
                    out_last      <= 1'b1;
                    sym_count     <= sym_count + CNT_W'(1);
                    enc_state_reg <= enc_next;
                    fsm_reg       <= IDLE;
                end
`endif
                default: fsm_reg <= IDLE;
            endcase
        end
    end

endmodule
